core_run_monitor: RTL and testbench

- Synthesizable, parametrised run-status monitor for the pipelined RV64I+Zba core.
- Sits beside `core` and snoops the fetch PC and the register-file write port.
- Decides PASS, FAIL, TIMEOUT or HANG for a software test and reports it as sticky status.
- Counts cycles and x0-write violations, so the same checks work in simulation, on FPGA and in regression.

---
 rtl/core_run_monitor_pkg.sv | 21 ++
 rtl/core_run_monitor_if.sv | 30 +++
 rtl/core_run_monitor_sat_counter.sv | 22 ++
 rtl/core_run_monitor.sv | 165 ++++++++++++++++
 tb/tb_core_run_monitor.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_run_monitor_pkg.sv
// Shared types and constants for the core run-status monitor.
package monitor_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_HANG    = 3'd5,
    ST_BADPC   = 3'd6
  } run_status_e;

  function automatic logic is_terminal(run_status_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT) ||
           (s == ST_HANG) || (s == ST_BADPC);
  endfunction

endpackage

// File: rtl/core_run_monitor_if.sv
// Snoop inputs from the core and status outputs of the run monitor.
interface core_run_monitor_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);

  logic [XLEN-1:0]                    pc_f;
  logic                               pc_valid;
  logic                               wb_we;
  logic [monitor_pkg::REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]                    wb_data;

  logic                               done;
  logic [2:0]                         status;
  logic [CNT_W-1:0]                   cycle_count;
  logic [CNT_W-1:0]                   x0_viol_count;
  logic [XLEN-1:0]                    sig_shadow;
  logic [XLEN-1:0]                    last_pc;

  modport master (
    output pc_f, pc_valid, wb_we, wb_rd, wb_data,
    input  done, status, cycle_count, x0_viol_count, sig_shadow, last_pc
  );

  modport slave (
    input  pc_f, pc_valid, wb_we, wb_rd, wb_data,
    output done, status, cycle_count, x0_viol_count, sig_shadow, last_pc
  );

endinterface

// File: rtl/core_run_monitor_sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over inc.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/core_run_monitor.sv
// Run-status monitor: watches fetch PC and register writeback, decides
// PASS/FAIL/TIMEOUT/HANG/BADPC and holds the verdict until reset.
//
// state   | meaning
// RUN     | test executing, all checks armed
// DRAIN   | pass value seen, waiting for the pipeline to settle
// PASS    | drain finished without a contradicting signature write
// FAIL    | fail value written to the signature register
// TIMEOUT | run exceeded the cycle budget
// HANG    | fetch PC unchanged for too long
// BADPC   | fetch PC flagged invalid while running
module core_run_monitor
  import monitor_pkg::*;
#(
  parameter int              XLEN           = 64,
  parameter int              CNT_W          = 32,
  parameter int              SIG_REG        = 31,
  parameter logic [XLEN-1:0] PASS_VALUE     = 64'h7FB,
  parameter logic [XLEN-1:0] FAIL_VALUE     = 64'hBAD,
  parameter int              DRAIN_CYCLES   = 10,
  parameter int              TIMEOUT_CYCLES = 1000,
  parameter int              STALL_LIMIT    = 256
) (
  input logic               clk,
  input logic               rst,
  core_run_monitor_if.slave mon
);

  if (PASS_VALUE == FAIL_VALUE || SIG_REG == 0 || TIMEOUT_CYCLES == 0 ||
      STALL_LIMIT == 0) begin : g_param_check
    $error("core_run_monitor: illegal parameter combination");
  end

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD =
    DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE   = DRAIN_W'(1);
  localparam logic [CNT_W-1:0]   TIMEOUT_TC  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STALL_TC    = CNT_W'(STALL_LIMIT - 1);
  localparam logic [REG_ADDR_W-1:0] SIG_ADDR = REG_ADDR_W'(SIG_REG);

  run_status_e        state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [XLEN-1:0]    pc_prev_q;
  logic [XLEN-1:0]    sig_q;
  logic [XLEN-1:0]    last_pc_q;
  logic               done_q;

  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   x0_cnt;
  logic [CNT_W-1:0]   stall_cnt;

  logic in_run, in_drain, active;
  logic sig_wr, sig_fail, sig_pass, x0_wr, pc_moved;
  logic timeout_hit, hang_hit;

  assign in_run   = (state_q == ST_RUN);
  assign in_drain = (state_q == ST_DRAIN);
  assign active   = in_run || in_drain;

  assign sig_wr   = mon.wb_we && (mon.wb_rd == SIG_ADDR);
  assign sig_fail = sig_wr && (mon.wb_data == FAIL_VALUE);
  assign sig_pass = sig_wr && (mon.wb_data == PASS_VALUE);
  assign x0_wr    = mon.wb_we && (mon.wb_rd == '0) && (mon.wb_data != '0);
  assign pc_moved = (mon.pc_f != pc_prev_q);

  assign timeout_hit = (cycle_cnt == TIMEOUT_TC);
  assign hang_hit    = (stall_cnt == STALL_TC);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (active),
    .q   (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_x0_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (active && x0_wr),
    .q   (x0_cnt)
  );

  // Only meaningful in RUN; held at zero elsewhere so a return from DRAIN starts fresh.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (!in_run || pc_moved),
    .inc (1'b1),
    .q   (stall_cnt)
  );

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      ST_RUN: begin
        if (!mon.pc_valid) begin
          state_d = ST_BADPC;
        end else if (sig_fail) begin
          state_d = ST_FAIL;
        end else if (sig_pass) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_PASS;
          end else begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end else if (timeout_hit) begin
          state_d = ST_TIMEOUT;
        end else if (hang_hit) begin
          state_d = ST_HANG;
        end
      end
      ST_DRAIN: begin
        // The core may legally run off the end of the test here, so PC validity is ignored.
        if (sig_fail) begin
          state_d = ST_FAIL;
        end else if (sig_wr) begin
          state_d = ST_RUN;
          drain_d = '0;
        end else if (drain_q == '0) begin
          state_d = ST_PASS;
        end else begin
          drain_d = drain_q - DRAIN_ONE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_RUN;
      drain_q   <= '0;
      pc_prev_q <= '0;
      sig_q     <= '0;
      last_pc_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      pc_prev_q <= mon.pc_f;
      if (active && sig_wr) begin
        sig_q <= mon.wb_data;
      end
      if (active && is_terminal(state_d)) begin
        last_pc_q <= mon.pc_f;
        done_q    <= 1'b1;
      end
    end
  end

  assign mon.done          = done_q;
  assign mon.status        = state_q;
  assign mon.cycle_count   = cycle_cnt;
  assign mon.x0_viol_count = x0_cnt;
  assign mon.sig_shadow    = sig_q;
  assign mon.last_pc       = last_pc_q;

endmodule

// File: tb/tb_core_run_monitor.sv
// Self-checking bench for core_run_monitor: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_core_run_monitor;

  localparam int XLEN  = 64;
  localparam int CNT_W = 32;
  localparam int SIG   = 31;
  localparam int DRAIN = 10;
  localparam int TO    = 50;
  localparam int SL    = 8;
  localparam logic [63:0] PASS_V = 64'h7FB;
  localparam logic [63:0] FAIL_V = 64'hBAD;

  localparam int S_RUN = 0, S_DRAIN = 1, S_PASS = 2, S_FAIL = 3;
  localparam int S_TIMEOUT = 4, S_HANG = 5, S_BADPC = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  core_run_monitor_if #(.XLEN(XLEN), .CNT_W(CNT_W)) mif ();
  core_run_monitor_if #(.XLEN(XLEN), .CNT_W(CNT_W)) mif0 ();

  assign mif0.pc_f     = mif.pc_f;
  assign mif0.pc_valid = mif.pc_valid;
  assign mif0.wb_we    = mif.wb_we;
  assign mif0.wb_rd    = mif.wb_rd;
  assign mif0.wb_data  = mif.wb_data;

  core_run_monitor #(
    .XLEN(XLEN), .CNT_W(CNT_W), .SIG_REG(SIG), .PASS_VALUE(PASS_V),
    .FAIL_VALUE(FAIL_V), .DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TO),
    .STALL_LIMIT(SL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (mif)
  );

  core_run_monitor #(
    .XLEN(XLEN), .CNT_W(CNT_W), .SIG_REG(SIG), .PASS_VALUE(PASS_V),
    .FAIL_VALUE(FAIL_V), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(TO),
    .STALL_LIMIT(SL)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .mon (mif0)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_st;
  int          m_drain;
  logic [31:0] m_cc, m_x0, m_stall;
  logic [63:0] m_sig, m_last, m_prev;
  bit          m_done;

  logic [63:0] pc_cur;

  typedef struct {
    bit          r;
    bit          v;
    bit          we;
    logic [4:0]  rd;
    logic [63:0] d;
    int          st;
    bit          dn;
    logic [31:0] x0;
    logic [63:0] sig;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input logic [63:0] pc, input bit v,
                            input bit we, input logic [4:0] rd, input logic [63:0] d);
    bit sig_w, x0v, live;
    int nst;
    if (!r) begin
      m_st = S_RUN; m_drain = 0; m_cc = 0; m_x0 = 0; m_stall = 0;
      m_sig = 0; m_last = 0; m_prev = 0; m_done = 0;
      return;
    end
    sig_w = we && (rd == 5'(SIG));
    x0v   = we && (rd == 5'd0) && (d != 64'd0);
    live  = (m_st == S_RUN) || (m_st == S_DRAIN);
    nst   = m_st;
    if (m_st == S_RUN) begin
      if (!v)                        nst = S_BADPC;
      else if (sig_w && d == FAIL_V) nst = S_FAIL;
      else if (sig_w && d == PASS_V) begin nst = S_DRAIN; m_drain = DRAIN - 1; end
      else if (m_cc == 32'(TO - 1))  nst = S_TIMEOUT;
      else if (m_stall == 32'(SL - 1)) nst = S_HANG;
    end else if (m_st == S_DRAIN) begin
      if (sig_w && d == FAIL_V) nst = S_FAIL;
      else if (sig_w)           begin nst = S_RUN; m_drain = 0; end
      else if (m_drain == 0)    nst = S_PASS;
      else                      m_drain = m_drain - 1;
    end
    if (live) begin
      if (m_cc != '1) m_cc = m_cc + 1;
      if (x0v && m_x0 != '1) m_x0 = m_x0 + 1;
      if (sig_w) m_sig = d;
    end
    m_stall = (m_st == S_RUN && pc == m_prev) ? m_stall + 1 : 32'd0;
    m_prev  = pc;
    if (live && nst >= S_PASS) begin
      m_last = pc;
      m_done = 1'b1;
    end
    m_st = nst;
  endtask

  task automatic cmp_model();
    chk("m_status", 64'(mif.status), 64'(m_st));
    chk("m_done", 64'(mif.done), 64'(m_done));
    chk("m_cycle_count", 64'(mif.cycle_count), 64'(m_cc));
    chk("m_x0_viol_count", 64'(mif.x0_viol_count), 64'(m_x0));
    chk("m_sig_shadow", mif.sig_shadow, m_sig);
    chk("m_last_pc", mif.last_pc, m_last);
  endtask

  task automatic cyc(input bit r, input logic [63:0] pc, input bit v,
                     input bit we, input logic [4:0] rd, input logic [63:0] d);
    rst          = r;
    mif.pc_f     = pc;
    mif.pc_valid = v;
    mif.wb_we    = we;
    mif.wb_rd    = rd;
    mif.wb_data  = d;
    @(posedge clk);
    model_edge(r, pc, v, we, rd, d);
    #1;
    cmp_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      pc_cur = pc_cur + 4;
      cyc(1'b1, pc_cur, 1'b1, 1'b0, 5'd0, 64'd0);
    end
  endtask

  task automatic wr(input logic [4:0] rd, input logic [63:0] d);
    pc_cur = pc_cur + 4;
    cyc(1'b1, pc_cur, 1'b1, 1'b1, rd, d);
  endtask

  task automatic do_reset();
    cyc(1'b0, 64'd0, 1'b1, 1'b0, 5'd0, 64'd0);
    pc_cur = 64'h1000;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] fail_pc;
    logic [63:0] d;
    logic [4:0]  rd;
    bit          we, v, stuck;

    mif.pc_f = '0; mif.pc_valid = 1'b1; mif.wb_we = 1'b0; mif.wb_rd = '0; mif.wb_data = '0;
    pc_cur = 64'h1000;

    // r, v, we, rd, data -> status, done, x0_viol_count, sig_shadow
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 5'd0,  64'h0,   S_RUN,   1'b0, 32'd0, 64'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 5'd0,  64'h5,   S_RUN,   1'b0, 32'd1, 64'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 5'd0,  64'h0,   S_RUN,   1'b0, 32'd1, 64'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 5'd5,  PASS_V,  S_RUN,   1'b0, 32'd1, 64'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 5'd31, 64'h123, S_RUN,   1'b0, 32'd1, 64'h123};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 5'd31, FAIL_V,  S_FAIL,  1'b1, 32'd1, FAIL_V};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 5'd31, PASS_V,  S_FAIL,  1'b1, 32'd1, FAIL_V};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 5'd0,  64'h9,   S_FAIL,  1'b1, 32'd1, FAIL_V};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 5'd0,  64'h0,   S_RUN,   1'b0, 32'd0, 64'h0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 5'd0,  64'h0,   S_BADPC, 1'b1, 32'd0, 64'h0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 5'd0,  64'h0,   S_RUN,   1'b0, 32'd0, 64'h0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 5'd31, PASS_V,  S_DRAIN, 1'b0, 32'd0, PASS_V};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 5'd0,  64'h0,   S_DRAIN, 1'b0, 32'd0, PASS_V};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 5'd31, PASS_V,  S_RUN,   1'b0, 32'd0, PASS_V};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 5'd31, PASS_V,  S_DRAIN, 1'b0, 32'd0, PASS_V};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 5'd31, FAIL_V,  S_FAIL,  1'b1, 32'd0, FAIL_V};

    for (int i = 0; i < 16; i++) begin
      pc_cur = pc_cur + 4;
      cyc(tbl[i].r, pc_cur, tbl[i].v, tbl[i].we, tbl[i].rd, tbl[i].d);
      chk($sformatf("vec%0d_status", i), 64'(mif.status), 64'(tbl[i].st));
      chk($sformatf("vec%0d_done", i), 64'(mif.done), 64'(tbl[i].dn));
      chk($sformatf("vec%0d_x0", i), 64'(mif.x0_viol_count), 64'(tbl[i].x0));
      chk($sformatf("vec%0d_sig", i), mif.sig_shadow, tbl[i].sig);
    end

    // Pass with drain: write on the 20th cycle, verdict after 10 drain cycles
    do_reset();
    idle(19);
    chk("t1_cc_before", 64'(mif.cycle_count), 64'd19);
    wr(5'd31, PASS_V);
    chk("t1_drain_entry", 64'(mif.status), 64'd1);
    for (int i = 0; i < 9; i++) begin
      idle(1);
      chk("t1_drain_hold", 64'(mif.status), 64'd1);
    end
    idle(1);
    chk("t1_pass", 64'(mif.status), 64'd2);
    chk("t1_done", 64'(mif.done), 64'd1);
    chk("t1_sig", mif.sig_shadow, 64'h7FB);
    chk("t1_cc", 64'(mif.cycle_count), 64'd30);
    idle(3);
    chk("t1_cc_frozen", 64'(mif.cycle_count), 64'd30);

    // Fail, last_pc capture, later pass write ignored
    do_reset();
    idle(14);
    pc_cur = pc_cur + 4;
    fail_pc = pc_cur;
    cyc(1'b1, fail_pc, 1'b1, 1'b1, 5'd31, FAIL_V);
    chk("t2_fail", 64'(mif.status), 64'd3);
    chk("t2_last_pc", mif.last_pc, fail_pc);
    wr(5'd31, PASS_V);
    chk("t2_sticky", 64'(mif.status), 64'd3);

    // Timeout, then pass write on the timeout cycle wins
    do_reset();
    idle(49);
    chk("t3_pre", 64'(mif.status), 64'd0);
    idle(1);
    chk("t3_timeout", 64'(mif.status), 64'd4);
    chk("t3_cc", 64'(mif.cycle_count), 64'd50);
    do_reset();
    idle(49);
    wr(5'd31, PASS_V);
    chk("t3_tie_drain", 64'(mif.status), 64'd1);
    idle(10);
    chk("t3_tie_pass", 64'(mif.status), 64'd2);

    // Hang on a stuck PC; the same stuck PC during DRAIN is harmless
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 64'h100, 1'b1, 1'b0, 5'd0, 64'd0);
    chk("t4_pre_hang", 64'(mif.status), 64'd0);
    cyc(1'b1, 64'h100, 1'b1, 1'b0, 5'd0, 64'd0);
    chk("t4_hang", 64'(mif.status), 64'd5);
    chk("t4_last_pc", mif.last_pc, 64'h100);
    do_reset();
    idle(3);
    wr(5'd31, PASS_V);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 64'h100, 1'b1, 1'b0, 5'd0, 64'd0);
      chk("t4_drain_nohang", 64'(mif.status), (i < 9) ? 64'd1 : 64'd2);
    end

    // Reset in the middle of DRAIN
    do_reset();
    idle(20);
    wr(5'd31, PASS_V);
    idle(4);
    chk("t6_in_drain", 64'(mif.status), 64'd1);
    chk("t6_cc25", 64'(mif.cycle_count), 64'd25);
    cyc(1'b0, pc_cur, 1'b1, 1'b0, 5'd0, 64'd0);
    chk("t6_status", 64'(mif.status), 64'd0);
    chk("t6_done", 64'(mif.done), 64'd0);
    chk("t6_cc", 64'(mif.cycle_count), 64'd0);
    chk("t6_sig", mif.sig_shadow, 64'd0);
    idle(1);
    chk("t6_restart", 64'(mif.cycle_count), 64'd1);

    // Zero drain length goes straight to PASS
    do_reset();
    idle(2);
    wr(5'd31, PASS_V);
    chk("d0_status", 64'(mif0.status), 64'd2);
    chk("d0_done", 64'(mif0.done), 64'd1);

    // Randomized traffic against the model
    for (int run = 0; run < 40; run++) begin
      do_reset();
      stuck = (run % 3 == 0);
      for (int c = 0; c < 70; c++) begin
        if (stuck ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0))
          pc_cur = pc_cur + 4;
        v  = ($urandom_range(0, 39) != 0);
        we = ($urandom_range(0, 2) == 0);
        case ($urandom_range(0, 2))
          0:       rd = 5'd0;
          1:       rd = 5'd31;
          default: rd = 5'($urandom_range(0, 31));
        endcase
        case ($urandom_range(0, 9))
          0, 1, 2: d = PASS_V;
          3:       d = FAIL_V;
          4, 5:    d = 64'd0;
          default: d = 64'($urandom_range(1, 15));
        endcase
        cyc(($urandom_range(0, 99) != 0), pc_cur, v, we, rd, d);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
